// File: rtl/riscv_pkg.sv
// Shared RISC-V decode constants and fetch-stage state encoding.
// Build option FETCH_ILLEGAL_HALT_EN adds the StHalt fetch state.
package riscv_pkg;

  // Major opcodes (inst[6:0]) understood by the execute datapath.
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;

  // addi x0,x0,0
  localparam logic [31:0] NOP = 32'h00000013;

`ifdef FETCH_ILLEGAL_HALT_EN
  typedef enum logic [1:0] {StIdle, StReq, StHold, StHalt} fetch_state_e;
`else
  typedef enum logic [1:0] {StIdle, StReq, StHold} fetch_state_e;
`endif

  // Sign-extend a 12-bit immediate field to 64 bits.
  function automatic logic [63:0] sext12(input logic [11:0] v);
    return {{52{v[11]}}, v};
  endfunction

  // True for the opcodes the execute datapath implements.
  function automatic logic is_legal_opcode(input logic [6:0] op);
    return op inside {OP_LOAD, OP_IMM, OP_STORE, OP_BRANCH, OP_RTYPE};
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Immediate generator: decodes the sign-extended immediate and opcode legality
// from a 32-bit instruction. Purely combinational.
module imm_gen
  import riscv_pkg::*;
(
  input  logic [31:0] inst,
  output logic [63:0] imm,
  output logic        opcode_legal
);

  // rs1/funct3 field carries no immediate bits in any supported format
  logic unused_mid_fields;
  assign unused_mid_fields = ^inst[19:12];

  // Select the immediate layout by opcode; R-type and unknown opcodes yield 0.
  always_comb begin
    imm = '0;
    case (inst[6:0])
      OP_LOAD, OP_IMM: imm = sext12(inst[31:20]);
      OP_STORE:        imm = sext12({inst[31:25], inst[11:7]});
      // Branch offset kept in half-words; the fetch unit shifts it left by one.
      OP_BRANCH:       imm = sext12({inst[31], inst[7], inst[30:25], inst[11:8]});
      default:         imm = '0;
    endcase
  end

  assign opcode_legal = is_legal_opcode(inst[6:0]);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches over an imem req/ack handshake,
// holds one instruction for the execute datapath and computes the next PC.
// Build option FETCH_ILLEGAL_HALT_EN: an unsupported opcode halts fetch and
// raises `illegal` until reset; otherwise `illegal` is tied low.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter logic [31:0] NOP_INST = NOP
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic [63:0] imm,
  output logic [63:0] pc,
  output logic        inst_valid,
  input  logic        exec_done,
  input  logic        branch,
  input  logic        zero,
  output logic        illegal
);

  fetch_state_e state_q;
  logic [63:0]  pc_q;
  logic [31:0]  inst_q;
  logic         valid_q;
  logic         req_q;
  logic [63:0]  next_pc;
  logic         inst_legal;

  imm_gen u_imm_gen (
    .inst         (inst_q),
    .imm          (imm),
    .opcode_legal (inst_legal)
  );

  // Legality of the held word is only of interest to the execute side.
  logic unused_inst_legal;
  assign unused_inst_legal = inst_legal;

  // Taken branch adds the half-word offset; wrap past 2^64 is intentional.
  always_comb begin
    next_pc = pc_q + 64'd4;
    if (branch && zero) begin
      next_pc = pc_q + (imm << 1);
    end
  end

`ifdef FETCH_ILLEGAL_HALT_EN
  logic illegal_q;
  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

  // Fetch sequencer: state, PC, held instruction and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
      inst_q  <= NOP_INST;
      valid_q <= 1'b0;
      req_q   <= 1'b0;
`ifdef FETCH_ILLEGAL_HALT_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          state_q <= StReq;
          req_q   <= 1'b1;
        end
        StReq: begin
          // req and addr stay put until memory answers; no timeout
          if (imem_ack) begin
            req_q  <= 1'b0;
            inst_q <= imem_rdata;
`ifdef FETCH_ILLEGAL_HALT_EN
            if (!is_legal_opcode(imem_rdata[6:0])) begin
              illegal_q <= 1'b1;
              state_q   <= StHalt;
            end else begin
              valid_q <= 1'b1;
              state_q <= StHold;
            end
`else
            valid_q <= 1'b1;
            state_q <= StHold;
`endif
          end
        end
        StHold: begin
          if (exec_done) begin
            valid_q <= 1'b0;
            inst_q  <= NOP_INST;
            pc_q    <= next_pc;
            req_q   <= 1'b1;
            state_q <= StReq;
          end
        end
`ifdef FETCH_ILLEGAL_HALT_EN
        // Sticky until reset; exec_done is ignored here.
        StHalt: state_q <= StHalt;
`endif
        default: state_q <= StIdle;
      endcase
    end
  end

  assign imem_req   = req_q;
  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign inst       = inst_q;
  assign inst_valid = valid_q;

endmodule
